// File: rtl/if_types_pkg.sv
// Shared interface types for the cache OBI register window: OBI request/response
// structs, register offsets, STATUS bits, op-codes and initiator FSM enums.
package if_types_pkg;

  localparam int OP_WIDTH    = 8;
  localparam int KEY_WIDTH   = 32;
  localparam int NUM_OFFSETS = 2;
  localparam int VALUE_WIDTH = 32 * NUM_OFFSETS;

  localparam logic [31:0] REG_OP_OFS     = 32'h00;
  localparam logic [31:0] REG_KEY_OFS    = 32'h04;
  localparam logic [31:0] REG_VAL_OFS    = 32'h08;
  localparam logic [31:0] REG_STATUS_OFS = 32'h10;

  localparam int STATUS_DONE_BIT = 0;
  localparam int STATUS_HIT_BIT  = 1;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_GET = OP_WIDTH'(1),
    OP_PUT = OP_WIDTH'(2),
    OP_DEL = OP_WIDTH'(3)
  } cache_op_e;

  typedef enum logic [2:0] {
    STEP_KEY, STEP_VAL, STEP_OP, STEP_STATUS, STEP_READ
  } init_step_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_RDATA, ST_GAP, ST_RESP
  } init_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        aid;
  } obi_a_t;

  typedef struct packed {
    logic   req;
    obi_a_t a;
    logic   rready;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_r_t;

  typedef struct packed {
    logic   gnt;
    logic   rvalid;
    obi_r_t r;
  } obi_rsp_t;

endpackage

// File: rtl/obi_single_txn.sv
// One OBI transaction: drives the A-phase while addr_phase_i is set and reports
// grant, R-beat completion, read data and error back to the sequencer.
module obi_single_txn
  import if_types_pkg::*;
(
  input  logic        addr_phase_i,
  input  logic        rdata_phase_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output obi_req_t    obi_req_o,
  input  obi_rsp_t    obi_rsp_i,
  output logic        gnt_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  // A fields are zero whenever no request is pending
  always_comb begin
    obi_req_o        = '0;
    obi_req_o.rready = 1'b1;
    if (addr_phase_i) begin
      obi_req_o.req     = 1'b1;
      obi_req_o.a.addr  = addr_i;
      obi_req_o.a.we    = we_i;
      obi_req_o.a.be    = 4'hF;
      obi_req_o.a.wdata = wdata_i;
      obi_req_o.a.aid   = 1'b0;
    end
  end

  assign gnt_o   = addr_phase_i & obi_rsp_i.gnt;
  assign done_o  = rdata_phase_i & obi_rsp_i.rvalid;
  assign rdata_o = obi_rsp_i.r.rdata;
  assign err_o   = obi_rsp_i.r.err;

endmodule

// File: rtl/obi_cache_initiator.sv
// Host-command to cache OBI sequencer: KEY, VALUE (PUT), OP writes, STATUS polling, VALUE read-back (GET).
// Optional STATUS poll timeout enabled by defining OBI_INIT_POLL_TIMEOUT_EN.
module obi_cache_initiator
  import if_types_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned POLL_GAP   = 4,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [OP_WIDTH-1:0]    cmd_op_i,
  input  logic [KEY_WIDTH-1:0]   cmd_key_i,
  input  logic [VALUE_WIDTH-1:0] cmd_value_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [VALUE_WIDTH-1:0] rsp_value_o,
  output logic                   rsp_hit_o,
  output logic                   rsp_err_o,
  output obi_req_t               obi_req_o,
  input  obi_rsp_t               obi_rsp_i
);

  // IDLE wait cmd | ADDR A-phase | RDATA await R beat | GAP poll spacing | RESP hold response
  localparam int unsigned      IDX_W    = (NUM_OFFSETS > 1) ? $clog2(NUM_OFFSETS) : 1;
  localparam int unsigned      GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (POLL_GAP > 0) ? GAP_W'(POLL_GAP - 1) : '0;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OFFSETS - 1);

  init_state_e                  state_q, state_d;
  init_step_e                   step_q, step_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [GAP_W-1:0]             gap_q, gap_d;
  logic [OP_WIDTH-1:0]          op_q, op_d;
  logic [KEY_WIDTH-1:0]         key_q, key_d;
  logic [NUM_OFFSETS-1:0][31:0] wval_q, wval_d;
  logic [NUM_OFFSETS-1:0][31:0] rval_q, rval_d;
  logic                         hit_q, hit_d, err_q, err_d;
  logic                         accept, poll_last;
  logic [31:0]                  txn_addr, txn_wdata, txn_rdata;
  logic                         txn_we, txn_gnt, txn_done, txn_err;

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign accept      = cmd_valid_i & cmd_ready_o;
  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_value_o = rval_q;
  assign rsp_hit_o   = hit_q;
  assign rsp_err_o   = err_q;

  always_comb begin
    txn_addr  = BASE_ADDR + REG_STATUS_OFS;
    txn_we    = 1'b0;
    txn_wdata = '0;
    case (step_q)
      STEP_KEY: begin
        txn_addr  = BASE_ADDR + REG_KEY_OFS;
        txn_we    = 1'b1;
        txn_wdata = key_q;
      end
      STEP_VAL: begin
        txn_addr  = BASE_ADDR + REG_VAL_OFS + (32'(idx_q) << 2);
        txn_we    = 1'b1;
        txn_wdata = wval_q[idx_q];
      end
      STEP_OP: begin
        txn_addr  = BASE_ADDR + REG_OP_OFS;
        txn_we    = 1'b1;
        txn_wdata = 32'(op_q);
      end
      STEP_READ: txn_addr = BASE_ADDR + REG_VAL_OFS + (32'(idx_q) << 2);
      default: ;
    endcase
  end

  obi_single_txn u_txn (
    .addr_phase_i  (state_q == ST_ADDR),
    .rdata_phase_i (state_q == ST_RDATA),
    .addr_i        (txn_addr),
    .we_i          (txn_we),
    .wdata_i       (txn_wdata),
    .obi_req_o     (obi_req_o),
    .obi_rsp_i     (obi_rsp_i),
    .gnt_o         (txn_gnt),
    .done_o        (txn_done),
    .rdata_o       (txn_rdata),
    .err_o         (txn_err)
  );

`ifdef OBI_INIT_POLL_TIMEOUT_EN
  localparam int unsigned PW = $clog2(POLL_LIMIT + 1);
  logic [PW-1:0] poll_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                   poll_cnt_q <= '0;
    else if (accept)                             poll_cnt_q <= '0;
    else if (txn_done && step_q == STEP_STATUS)  poll_cnt_q <= poll_cnt_q + 1'b1;
  end

  assign poll_last = (poll_cnt_q == PW'(POLL_LIMIT - 1));
`else
  logic unused_poll_limit;
  assign unused_poll_limit = (POLL_LIMIT != 0);
  assign poll_last         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    op_d    = op_q;
    key_d   = key_q;
    wval_d  = wval_q;
    rval_d  = rval_q;
    hit_d   = hit_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        op_d    = cmd_op_i;
        key_d   = cmd_key_i;
        wval_d  = cmd_value_i;
        rval_d  = '0;
        hit_d   = 1'b0;
        err_d   = 1'b0;
        step_d  = STEP_KEY;
        idx_d   = '0;
        state_d = ST_ADDR;
      end
      ST_ADDR: if (txn_gnt) state_d = ST_RDATA;
      ST_RDATA: if (txn_done) begin
        state_d = ST_ADDR;
        if (txn_err) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          case (step_q)
            STEP_KEY: begin
              idx_d  = '0;
              step_d = (op_q == OP_PUT) ? STEP_VAL : STEP_OP;
            end
            STEP_VAL: begin
              if (idx_q == IDX_LAST) step_d = STEP_OP;
              else                   idx_d  = idx_q + 1'b1;
            end
            STEP_OP: step_d = STEP_STATUS;
            STEP_STATUS: begin
              if (txn_rdata[STATUS_DONE_BIT]) begin
                hit_d = txn_rdata[STATUS_HIT_BIT];
                if (op_q == OP_GET) begin
                  step_d = STEP_READ;
                  idx_d  = '0;
                end else begin
                  state_d = ST_RESP;
                end
              end else if (poll_last) begin
                err_d   = 1'b1;
                hit_d   = 1'b0;
                state_d = ST_RESP;
              end else if (POLL_GAP > 0) begin
                gap_d   = GAP_LOAD;
                state_d = ST_GAP;
              end
            end
            STEP_READ: begin
              rval_d[idx_q] = txn_rdata;
              if (idx_q == IDX_LAST) state_d = ST_RESP;
              else                   idx_d   = idx_q + 1'b1;
            end
            default: state_d = ST_RESP;
          endcase
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_ADDR;
        else             gap_d   = gap_q - 1'b1;
      end
      ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      step_q  <= STEP_KEY;
      idx_q   <= '0;
      gap_q   <= '0;
      op_q    <= '0;
      key_q   <= '0;
      wval_q  <= '0;
      rval_q  <= '0;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      op_q    <= op_d;
      key_q   <= key_d;
      wval_q  <= wval_d;
      rval_q  <= rval_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
    end
  end

endmodule
